hazard_ctrl: RTL and testbench

Hazard controller for the 5-stage pipeline. It tracks the destination of the instructions in EX and MEM, and for each instruction in ID it produces the ID/EX register controls: `should_stall`, `fwd_a` and `fwd_b`. It also produces the fetch-side controls `pc_hold` and `if_flush`, and keeps saturating stall/flush performance counters. It sits beside the decode stage and drives the EX pipeline register, the PC register and the IF/ID register.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/hazard_ctrl_sat_counter.sv | 16 +
 rtl/hazard_ctrl.sv | 75 +++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, scoreboard entry type and flush FSM states
package cpu_pkg;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;
  typedef struct packed {
    logic                 valid;
    logic                 wr;
    logic [REG_IDX_W-1:0] rd;
    logic                 load;
  } sb_entry_t;
  typedef enum logic {RUN, SQUASH} flush_state_t;
  function automatic logic produces(input sb_entry_t e, input logic [REG_IDX_W-1:0] r);
    return e.valid & e.wr & (e.rd == r) & (r != ZERO_REG);
  endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
//   clk, rst_n (async active-low), inc: count enable, count: current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + W'(1);
  assign count = r_count;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward/flush control for the decode stage of a 5-stage pipeline
//   inputs : clk, rst_n (async active-low), ID instruction fields, ex_is_jump (raw ID/EX bit)
//   outputs: should_stall, pc_hold, if_flush, fwd_a, fwd_b, stall_count, flush_count
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic                 id_reg_wrenable,
  input  logic [REG_IDX_W-1:0] id_write_reg,
  input  logic                 id_mem_to_reg,
  input  logic                 ex_is_jump,
  output logic                 should_stall,
  output logic                 pc_hold,
  output logic                 if_flush,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);
  sb_entry_t    r_ex, r_mem, w_id_entry;
  flush_state_t r_state, w_state_next;
  logic w_live1, w_live2, w_ex1, w_ex2, w_mem1, w_mem2;
  logic w_jump, w_load_use, w_mem_dep, w_hold;
  assign w_id_entry = '{valid: id_valid, wr: id_reg_wrenable, rd: id_write_reg, load: id_mem_to_reg};
  assign w_live1 = id_valid & id_uses_rs1;
  assign w_live2 = id_valid & id_uses_rs2;
  assign w_ex1   = w_live1 & produces(r_ex, id_rs1);
  assign w_ex2   = w_live2 & produces(r_ex, id_rs2);
  assign w_mem1  = w_live1 & produces(r_mem, id_rs1);
  assign w_mem2  = w_live2 & produces(r_mem, id_rs2);
  // ex_is_jump survives bubbles, so only a valid EX entry may take a jump;
  // SQUASH always follows a jump with a bubble in EX, making the state gate redundant but explicit
  assign w_jump     = ex_is_jump & r_ex.valid & (r_state == RUN);
  assign w_load_use = (w_ex1 | w_ex2) & r_ex.load;
  assign w_mem_dep  = w_mem1 | w_mem2;
  assign w_hold     = ~w_jump & (w_load_use | w_mem_dep);
  always_comb begin
    should_stall = w_jump | w_hold;
    pc_hold      = w_hold;
    if_flush     = w_jump;
    fwd_a        = ~w_jump & w_ex1 & ~r_ex.load;
    fwd_b        = ~w_jump & w_ex2 & ~r_ex.load;
    w_state_next = (r_state == RUN && w_jump) ? SQUASH : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ex    <= '0;
      r_mem   <= '0;
      r_state <= RUN;
    end else begin
      r_mem   <= r_ex;
      r_ex    <= should_stall ? '0 : w_id_entry;
      r_state <= w_state_next;
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_hold),
    .count (stall_count)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_jump),
    .count (flush_count)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_wrenable, id_mem_to_reg, ex_is_jump;
  logic [4:0] id_rs1, id_rs2, id_write_reg;
  logic should_stall, pc_hold, if_flush, fwd_a, fwd_b;
  logic [15:0] stall_count, flush_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .id_reg_wrenable (id_reg_wrenable),
    .id_write_reg    (id_write_reg),
    .id_mem_to_reg   (id_mem_to_reg),
    .ex_is_jump      (ex_is_jump),
    .should_stall    (should_stall),
    .pc_hold         (pc_hold),
    .if_flush        (if_flush),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_count     (stall_count),
    .flush_count     (flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected vector order: {should_stall, pc_hold, if_flush, fwd_a, fwd_b}
  task automatic exp_o(input string tag, input logic [4:0] e);
    #1;
    chk(tag, {27'd0, should_stall, pc_hold, if_flush, fwd_a, fwd_b}, {27'd0, e});
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic we, input logic [4:0] rd,
                     input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_reg_wrenable = we; id_write_reg = rd; id_mem_to_reg = ld;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_is_jump = 1'b1;
    drv(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1);
    #12;
    exp_o("rst_outputs", 5'b00000);
    chk("rst_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_flush_cnt", 32'(flush_count), 32'd0);
    ex_is_jump = 1'b0;
    idle();
    rst_n = 1'b1;
    tick();
    // ALU forward: add x5 ; sub x8, x5, x6
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
    exp_o("alu_prod", 5'b00000);
    tick();
    drv(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0);
    exp_o("fwd_a", 5'b00010);
    tick();
    chk("fwd_stall_cnt", 32'(stall_count), 32'd0);
    drv(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    exp_o("fwd_both", 5'b00011);
    tick();
    // rs1 hits MEM (stall), rs2 hits EX ALU (forward)
    drv(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    exp_o("mix_c1", 5'b11001);
    tick();
    chk("mix_cnt1", 32'(stall_count), 32'd1);
    exp_o("mix_c2", 5'b11000);
    tick();
    chk("mix_cnt2", 32'(stall_count), 32'd2);
    exp_o("mix_issue", 5'b00000);
    tick();
    idle();
    tick();
    tick();
    // load-use: lw x7 ; add x9, x3, x7
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    exp_o("lw_issue", 5'b00000);
    tick();
    drv(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    exp_o("lu_c1", 5'b11000);
    tick();
    chk("lu_cnt1", 32'(stall_count), 32'd3);
    exp_o("lu_c2", 5'b11000);
    tick();
    chk("lu_cnt2", 32'(stall_count), 32'd4);
    exp_o("lu_issue", 5'b00000);
    tick();
    idle();
    tick();
    tick();
    // register 0 never matches, in EX or in MEM
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    exp_o("r0_ex", 5'b00000);
    tick();
    exp_o("r0_mem", 5'b00000);
    chk("r0_stall_cnt", 32'(stall_count), 32'd4);
    idle();
    tick();
    tick();
    // jump taken with valid EX, then stale is_jump behind the bubble
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 1'b0);
    tick();
    ex_is_jump = 1'b1;
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd11, 1'b0);
    exp_o("jmp", 5'b10100);
    tick();
    chk("jmp_flush_cnt", 32'(flush_count), 32'd1);
    exp_o("jmp_bubble", 5'b00000);
    ex_is_jump = 1'b0;
    tick();
    chk("jmp_flush_hold", 32'(flush_count), 32'd1);
    chk("jmp_stall_cnt", 32'(stall_count), 32'd4);
    idle();
    tick();
    tick();
    // jump coincident with load-use: jump wins, no stall counted
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    tick();
    ex_is_jump = 1'b1;
    drv(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    exp_o("jmp_lu", 5'b10100);
    tick();
    ex_is_jump = 1'b0;
    chk("jmp_lu_stall_cnt", 32'(stall_count), 32'd4);
    chk("jmp_lu_flush_cnt", 32'(flush_count), 32'd2);
    idle();
    tick();
    tick();
    // asynchronous reset in cycle 1 of a load-use stall
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1);
    tick();
    drv(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    exp_o("rst_pre", 5'b11000);
    #2;
    rst_n = 1'b0;
    exp_o("rst_mid", 5'b00000);
    chk("rst_mid_stall_cnt", 32'(stall_count), 32'd0);
    chk("rst_mid_flush_cnt", 32'(flush_count), 32'd0);
    rst_n = 1'b1;
    exp_o("rst_release", 5'b00000);
    tick();
    chk("rst_no_stall", 32'(stall_count), 32'd0);
    exp_o("rst_after", 5'b00000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
